// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Requests are accepted in IDLE
// with round-robin arbitration, run for one EXEC cycle, and the result is held until accepted.
module alu_share_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [15:0]           r0_op,
  input  logic [DATA_WIDTH-1:0] r0_a,
  input  logic [DATA_WIDTH-1:0] r0_b,
  output logic                  r0_rsp_valid,
  input  logic                  r0_rsp_ready,
  output logic [DATA_WIDTH-1:0] r0_rsp_data,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [15:0]           r1_op,
  input  logic [DATA_WIDTH-1:0] r1_a,
  input  logic [DATA_WIDTH-1:0] r1_b,
  output logic                  r1_rsp_valid,
  input  logic                  r1_rsp_ready,
  output logic [DATA_WIDTH-1:0] r1_rsp_data,
  output logic                  alu_e,
  output logic [15:0]           alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [15:0]           op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic                  gnt_q, last_q;
  logic                  win0, win1;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    win0 = r0_valid && (!r1_valid || last_q);
    win1 = r1_valid && (!r0_valid || !last_q);
  end

  always_comb begin
    state_d      = state_q;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    alu_e        = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        r0_ready = win0;
        r1_ready = win1;
        if (win0 || win1) state_d = EXEC;
      end
      EXEC: begin
        alu_e   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        r0_rsp_valid = !gnt_q;
        r1_rsp_valid = gnt_q;
        if (gnt_q ? r1_rsp_ready : r0_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (win0 || win1)) begin
        op_q   <= win1 ? r1_op : r0_op;
        a_q    <= win1 ? r1_a  : r0_a;
        b_q    <= win1 ? r1_b  : r0_b;
        gnt_q  <= win1;
        last_q <= win1;
      end
      if (state_q == EXEC) res_q <= alu_out;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign r0_rsp_data = res_q;
  assign r1_rsp_data = res_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and randomized checks of alu_share_ctrl against a transaction-level model
// tracking the owner and age of the in-flight operation.
module tb_alu_share_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  logic [15:0]  r0_op;
  logic [W-1:0] r0_a, r0_b, r0_rsp_data;
  logic         r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  logic [15:0]  r1_op;
  logic [W-1:0] r1_a, r1_b, r1_rsp_data;
  logic         alu_e, busy;
  logic [15:0]  alu_op;
  logic [W-1:0] alu_a, alu_b, alu_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
    .alu_e(alu_e), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy)
  );

  function automatic logic [W-1:0] ref_alu(input logic [15:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      16'h0033: return a + b;
      16'h4033: return a - b;
      16'h7033: return a & b;
      16'h6033: return a | b;
      default:  return '0;
    endcase
  endfunction

  always_comb alu_out = ref_alu(alu_op, alu_a, alu_b);

  // Model: m_pend = an accepted operation exists, m_age = cycles since its accept edge.
  bit           m_pend, m_owner, m_last, acc0, acc1;
  int           m_age, cyc;
  logic [15:0]  m_op;
  logic [W-1:0] m_a, m_b, m_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_owner = 0; m_last = 1; m_age = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0;
  endtask

  task automatic cycle();
    bit w0, w1;
    #1;
    w0 = 0;
    w1 = 0;
    if (!m_pend) begin
      if (r0_valid && r1_valid) begin
        w0 = m_last;
        w1 = !m_last;
      end else begin
        w0 = r0_valid;
        w1 = r1_valid;
      end
    end
    chk("r0_ready", r0_ready, w0);
    chk("r1_ready", r1_ready, w1);
    chk("busy", busy, m_pend);
    chk("alu_e", alu_e, m_pend && m_age == 1);
    chk("r0_rsp_valid", r0_rsp_valid, m_pend && m_age >= 2 && !m_owner);
    chk("r1_rsp_valid", r1_rsp_valid, m_pend && m_age >= 2 && m_owner);
    chk("r0_rsp_data", r0_rsp_data, m_res);
    chk("r1_rsp_data", r1_rsp_data, m_res);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    acc0 = w0 && !rst;
    acc1 = w1 && !rst;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else if (m_pend) begin
      if (m_age == 1) begin
        m_res = ref_alu(m_op, m_a, m_b);
        m_age = 2;
      end else if (m_owner ? r1_rsp_ready : r0_rsp_ready) m_pend = 0;
      else m_age++;
    end else if (w0 || w1) begin
      m_pend = 1; m_age = 1; m_owner = w1; m_last = w1;
      m_op = w1 ? r1_op : r0_op;
      m_a  = w1 ? r1_a  : r0_a;
      m_b  = w1 ? r1_b  : r0_b;
    end
    #1;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] ops [5] = '{16'h0033, 16'h4033, 16'h7033, 16'h6033, 16'h1234};
    return ops[$urandom_range(0, 4)];
  endfunction

  int order[$];
  int acc_cyc[$];

  initial begin
    rst = 1; cyc = 0;
    r0_valid = 0; r0_op = '0; r0_a = '0; r0_b = '0; r0_rsp_ready = 0;
    r1_valid = 0; r1_op = '0; r1_a = '0; r1_b = '0; r1_rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    rst = 0;

    // Basic ADD on r0
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    r0_valid = 1; r0_op = 16'h0033; r0_a = 5; r0_b = 7;
    #1 chk("add_ready", r0_ready, 1);
    cycle();
    r0_valid = 0;
    cycle();
    chk("add_rsp_valid", r0_rsp_valid, 1);
    chk("add_data", r0_rsp_data, 12);
    cycle();
    cycle();

    // SUB wrap-around on r1
    r1_valid = 1; r1_op = 16'h4033; r1_a = 3; r1_b = 5;
    cycle();
    r1_valid = 0;
    cycle();
    chk("sub_rsp_valid", r1_rsp_valid, 1);
    chk("sub_data", r1_rsp_data, 32'hFFFF_FFFE);
    cycle();

    // Tie with both continuously valid
    r0_valid = 1; r0_op = 16'h0033; r0_a = 100; r0_b = 1;
    r1_valid = 1; r1_op = 16'h0033; r1_a = 200; r1_b = 2;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (acc0) begin order.push_back(0); acc_cyc.push_back(cyc); r0_a = 101 + k; end
      if (acc1) begin order.push_back(1); acc_cyc.push_back(cyc); r1_a = 201 + k; end
    end
    chk("tie_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk("tie_order", order[k], k % 2);
    for (int k = 1; k < acc_cyc.size(); k++) chk("tie_spacing", acc_cyc[k] - acc_cyc[k-1], 3);

    // Response backpressure on r0 with r1 waiting
    r0_rsp_ready = 0; r0_op = 16'h0033; r0_a = 32'h10; r0_b = 32'h20;
    cycle();
    r0_valid = 0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_hold_data", r0_rsp_data, 32'h30);
      chk("bp_hold_valid", r0_rsp_valid, 1);
      chk("bp_r1_blocked", r1_ready, 0);
      cycle();
    end
    r0_rsp_ready = 1;
    cycle();
    #1 chk("bp_r1_accept", r1_ready, 1);
    cycle();
    r1_valid = 0;
    repeat (3) cycle();

    // Reset in EXEC
    r0_valid = 1; r0_op = 16'h0033; r0_a = 9; r0_b = 9;
    cycle();
    r0_valid = 0; rst = 1;
    cycle();
    rst = 0;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", r0_rsp_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    r0_valid = 1; r1_valid = 1;
    #1 chk("post_rst_tie_r0", r0_ready, 1);
    chk("post_rst_tie_r1", r1_ready, 0);
    cycle();
    r0_valid = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (acc1) r1_valid = 0;
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      r0_rsp_ready = ($urandom_range(0, 9) < 7);
      r1_rsp_ready = ($urandom_range(0, 9) < 7);
      if (!r0_valid && $urandom_range(0, 1) == 1) begin
        r0_valid = 1; r0_op = rand_op(); r0_a = rand_val(); r0_b = rand_val();
      end
      if (!r1_valid && $urandom_range(0, 1) == 1) begin
        r1_valid = 1; r1_op = rand_op(); r1_a = rand_val(); r1_b = rand_val();
      end
      cycle();
      if (acc0) r0_valid = 0;
      if (acc1) r1_valid = 0;
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
